// File: rtl/combat_resolver_pkg.sv
// Shared encodings for the fighter blocks and the combat resolver:
// action one-hot bits, facing bit index, winner codes and round FSM states.
package combat_resolver_pkg;

    localparam int FACING_BIT = 6;

    localparam logic [5:0] ACT_WALKING   = 6'b000001;
    localparam logic [5:0] ACT_CROUCHING = 6'b000010;
    localparam logic [5:0] ACT_SHIELDING = 6'b000100;
    localparam logic [5:0] ACT_JUMPING   = 6'b001000;
    localparam logic [5:0] ACT_PUNCHING  = 6'b010000;
    localparam logic [5:0] ACT_STANDING  = 6'b100000;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P0   = 2'b01;
    localparam logic [1:0] WIN_P1   = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

    localparam logic [3:0] HEALTH_MAX = 4'd15;

    typedef enum logic {
        FIGHT = 1'b0,
        OVER  = 1'b1
    } round_state_e;

endpackage

// File: rtl/combat_resolver_hit_check.sv
// Combinational outcome of one attacker's punch against one defender:
// clean hit, block, or (neither asserted) miss.
module hit_check
    import combat_resolver_pkg::*;
#(
    parameter int             XW    = 10,
    parameter logic [XW-1:0]  REACH = 10'd48
) (
    input  logic [XW-1:0] att_x,
    input  logic          att_facing_left,
    input  logic          att_req,
    input  logic [XW-1:0] def_x,
    input  logic [5:0]    def_action,
    input  logic [3:0]    def_shield,
    input  logic          def_invuln,
    output logic          is_hit,
    output logic          is_block
);

    logic in_reach;
    logic dodging;
    logic shielding;
    logic connects;

    always_comb begin
        in_reach = 1'b0;
        // Ordering test first keeps the unsigned difference from wrapping.
        if (att_facing_left) begin
            if (att_x >= def_x) in_reach = ((att_x - def_x) <= REACH);
        end else begin
            if (def_x >= att_x) in_reach = ((def_x - att_x) <= REACH);
        end

        dodging   = |(def_action & (ACT_JUMPING | ACT_CROUCHING));
        shielding = |(def_action & ACT_SHIELDING);
        connects  = att_req && in_reach && !dodging && !def_invuln;

        is_block  = connects && shielding && (def_shield != 4'd0);
        is_hit    = connects && !is_block;
    end

endmodule

// File: rtl/combat_resolver.sv
// Resolves both players' punches each cycle, owns both health registers and
// the invulnerability timers, and runs the FIGHT/OVER round state machine.
module combat_resolver
    import combat_resolver_pkg::*;
#(
    parameter int             XW            = 10,
    parameter logic [XW-1:0]  REACH         = 10'd48,
    parameter logic [3:0]     DAMAGE        = 4'd2,
    parameter logic [3:0]     CHIP_DAMAGE   = 4'd0,
    parameter logic [23:0]    INVULN_CYCLES = 24'd12_500_000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          new_round,
    input  logic          attack_req0,
    input  logic          attack_req1,
    input  logic [6:0]    action0,
    input  logic [6:0]    action1,
    input  logic [3:0]    shield0,
    input  logic [3:0]    shield1,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    output logic [3:0]    health0,
    output logic [3:0]    health1,
    output logic          hit0,
    output logic          hit1,
    output logic          block0,
    output logic          block1,
    output logic          game_over,
    output logic [1:0]    winner
);

    function automatic logic [3:0] sat_sub(input logic [3:0] a, input logic [3:0] b);
        return (a > b) ? (a - b) : 4'd0;
    endfunction

    round_state_e state_q, state_d;
    logic [3:0]   health0_q, health0_d, health1_q, health1_d;
    logic [23:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic         hit0_q, hit0_d, hit1_q, hit1_d;
    logic         block0_q, block0_d, block1_q, block1_d;
    logic [1:0]   winner_q, winner_d;

    logic fighting;
    logic hit_on0, block_on0, hit_on1, block_on1;

    // A restart pulse suppresses any attack in the same cycle.
    assign fighting = (state_q == FIGHT) && !new_round;

    // Player 0 attacking player 1.
    hit_check #(.XW(XW), .REACH(REACH)) u_check_0to1 (
        .att_x           (x0),
        .att_facing_left (action0[FACING_BIT]),
        .att_req         (attack_req0 && fighting),
        .def_x           (x1),
        .def_action      (action1[5:0]),
        .def_shield      (shield1),
        .def_invuln      (cnt1_q != 24'd0),
        .is_hit          (hit_on1),
        .is_block        (block_on1)
    );

    // Player 1 attacking player 0.
    hit_check #(.XW(XW), .REACH(REACH)) u_check_1to0 (
        .att_x           (x1),
        .att_facing_left (action1[FACING_BIT]),
        .att_req         (attack_req1 && fighting),
        .def_x           (x0),
        .def_action      (action0[5:0]),
        .def_shield      (shield0),
        .def_invuln      (cnt0_q != 24'd0),
        .is_hit          (hit_on0),
        .is_block        (block_on0)
    );

    always_comb begin
        state_d   = state_q;
        health0_d = health0_q;
        health1_d = health1_q;
        cnt0_d    = (cnt0_q != 24'd0) ? cnt0_q - 24'd1 : cnt0_q;
        cnt1_d    = (cnt1_q != 24'd0) ? cnt1_q - 24'd1 : cnt1_q;
        hit0_d    = 1'b0;
        hit1_d    = 1'b0;
        block0_d  = 1'b0;
        block1_d  = 1'b0;
        winner_d  = winner_q;

        if (new_round) begin
            state_d   = FIGHT;
            health0_d = HEALTH_MAX;
            health1_d = HEALTH_MAX;
            cnt0_d    = 24'd0;
            cnt1_d    = 24'd0;
            winner_d  = WIN_NONE;
        end else if (state_q == FIGHT) begin
            if (hit_on0) begin
                health0_d = sat_sub(health0_q, DAMAGE);
                cnt0_d    = INVULN_CYCLES;
                hit0_d    = 1'b1;
            end else if (block_on0) begin
                health0_d = sat_sub(health0_q, CHIP_DAMAGE);
                block0_d  = 1'b1;
            end

            if (hit_on1) begin
                health1_d = sat_sub(health1_q, DAMAGE);
                cnt1_d    = INVULN_CYCLES;
                hit1_d    = 1'b1;
            end else if (block_on1) begin
                health1_d = sat_sub(health1_q, CHIP_DAMAGE);
                block1_d  = 1'b1;
            end

            if (health0_d == 4'd0 || health1_d == 4'd0) begin
                state_d = OVER;
                if (health0_d == 4'd0 && health1_d == 4'd0) winner_d = WIN_DRAW;
                else if (health1_d == 4'd0)                 winner_d = WIN_P0;
                else                                        winner_d = WIN_P1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FIGHT;
            health0_q <= HEALTH_MAX;
            health1_q <= HEALTH_MAX;
            cnt0_q    <= 24'd0;
            cnt1_q    <= 24'd0;
            hit0_q    <= 1'b0;
            hit1_q    <= 1'b0;
            block0_q  <= 1'b0;
            block1_q  <= 1'b0;
            winner_q  <= WIN_NONE;
        end else begin
            state_q   <= state_d;
            health0_q <= health0_d;
            health1_q <= health1_d;
            cnt0_q    <= cnt0_d;
            cnt1_q    <= cnt1_d;
            hit0_q    <= hit0_d;
            hit1_q    <= hit1_d;
            block0_q  <= block0_d;
            block1_q  <= block1_d;
            winner_q  <= winner_d;
        end
    end

    assign health0   = health0_q;
    assign health1   = health1_q;
    assign hit0      = hit0_q;
    assign hit1      = hit1_q;
    assign block0    = block0_q;
    assign block1    = block1_q;
    assign game_over = (state_q == OVER);
    assign winner    = winner_q;

endmodule

// File: tb/tb_combat_resolver.sv
// Self-checking bench for combat_resolver: vector table of single-punch cases
// plus hand-built sequences for invulnerability, knockout, restart and reset.
module tb_combat_resolver;

    localparam int          INV = 8;
    localparam logic [6:0]  L   = 7'b1000000;
    localparam logic [6:0]  WA  = 7'b0000001;
    localparam logic [6:0]  CR  = 7'b0000010;
    localparam logic [6:0]  SH  = 7'b0000100;
    localparam logic [6:0]  JU  = 7'b0001000;
    localparam logic [6:0]  PU  = 7'b0010000;
    localparam logic [6:0]  ST  = 7'b0100000;

    typedef struct packed {
        logic       hit0;
        logic       hit1;
        logic       block0;
        logic       block1;
        logic [3:0] health0;
        logic [3:0] health1;
        logic       game_over;
        logic [1:0] winner;
    } out_t;

    typedef struct {
        string      name;
        logic [9:0] x0, x1;
        logic [6:0] a0, a1;
        logic [3:0] s0, s1;
        logic       r0, r1;
        out_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset, new_round, attack_req0, attack_req1;
    logic [6:0] action0, action1;
    logic [3:0] shield0, shield1;
    logic [9:0] x0, x1;
    logic [3:0] health0, health1;
    logic       hit0, hit1, block0, block1, game_over;
    logic [1:0] winner;

    int   n_checks = 0;
    int   n_fail   = 0;
    out_t exp_q[$];
    vec_t tbl[$];

    combat_resolver #(.INVULN_CYCLES(24'(INV))) dut (
        .clk         (clk),
        .reset       (reset),
        .new_round   (new_round),
        .attack_req0 (attack_req0),
        .attack_req1 (attack_req1),
        .action0     (action0),
        .action1     (action1),
        .shield0     (shield0),
        .shield1     (shield1),
        .x0          (x0),
        .x1          (x1),
        .health0     (health0),
        .health1     (health1),
        .hit0        (hit0),
        .hit1        (hit1),
        .block0      (block0),
        .block1      (block1),
        .game_over   (game_over),
        .winner      (winner)
    );

    always #5 clk = ~clk;

    function automatic out_t mk(input logic h0, input logic h1, input logic b0, input logic b1,
                                input logic [3:0] hp0, input logic [3:0] hp1,
                                input logic go, input logic [1:0] w);
        out_t o;
        o.hit0 = h0; o.hit1 = h1; o.block0 = b0; o.block1 = b1;
        o.health0 = hp0; o.health1 = hp1; o.game_over = go; o.winner = w;
        return o;
    endfunction

    function automatic vec_t v(input string n, input logic [9:0] px0, input logic [9:0] px1,
                               input logic [6:0] pa0, input logic [6:0] pa1,
                               input logic [3:0] ps0, input logic [3:0] ps1,
                               input logic pr0, input logic pr1, input out_t e);
        vec_t t;
        t.name = n; t.x0 = px0; t.x1 = px1; t.a0 = pa0; t.a1 = pa1;
        t.s0 = ps0; t.s1 = ps1; t.r0 = pr0; t.r1 = pr1; t.exp = e;
        return t;
    endfunction

    task automatic check(input string name);
        out_t a, e;
        a = {hit0, hit1, block0, block1, health0, health1, game_over, winner};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: no expected entry in scoreboard", name);
        end else begin
            e = exp_q.pop_front();
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got hit=%b%b blk=%b%b hp=%0d/%0d go=%b win=%b, expected hit=%b%b blk=%b%b hp=%0d/%0d go=%b win=%b",
                         name, a.hit0, a.hit1, a.block0, a.block1, a.health0, a.health1, a.game_over, a.winner,
                         e.hit0, e.hit1, e.block0, e.block1, e.health0, e.health1, e.game_over, e.winner);
            end
        end
    endtask

    // Drive one cycle of control inputs at a falling edge, compare after the next one.
    task automatic cycle(input logic nr, input logic rst, input logic r0, input logic r1,
                         input out_t e, input string name);
        new_round = nr; reset = rst; attack_req0 = r0; attack_req1 = r1;
        exp_q.push_back(e);
        @(negedge clk);
        check(name);
        new_round = 1'b0; reset = 1'b0; attack_req0 = 1'b0; attack_req1 = 1'b0;
    endtask

    task automatic set_players(input logic [9:0] px0, input logic [9:0] px1,
                               input logic [6:0] pa0, input logic [6:0] pa1,
                               input logic [3:0] ps0, input logic [3:0] ps1);
        x0 = px0; x1 = px1; action0 = pa0; action1 = pa1; shield0 = ps0; shield1 = ps1;
    endtask

    // Bring both players to health 1 with timed trades, then deliver the final blow(s).
    task automatic ko_run(input logic r0, input logic r1, input out_t final_exp, input string name);
        logic [3:0] h;
        set_players(10'd100, 10'd120, PU, L | PU, 4'd0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 15, 15, 0, 2'b00), "ko_restart");
        for (int i = 0; i < 7; i++) begin
            h = 4'(13 - 2 * i);
            cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, h, h, 0, 2'b00), "ko_trade");
            for (int j = 0; j < INV + 2; j++)
                cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, h, h, 0, 2'b00), "ko_wait");
        end
        cycle(1'b0, 1'b0, r0, r1, final_exp, name);
    endtask

    initial begin
        out_t idle15;
        idle15 = mk(0, 0, 0, 0, 15, 15, 0, 2'b00);
        reset = 1'b1; new_round = 1'b0; attack_req0 = 1'b0; attack_req1 = 1'b0;
        set_players(10'd100, 10'd130, PU, ST, 4'd0, 4'd0);

        cycle(1'b0, 1'b1, 1'b0, 1'b0, idle15, "reset_state");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, idle15, "idle_after_reset");

        tbl.push_back(v("clean_hit",      100, 130, PU,     ST,     0, 0, 1, 0, mk(0, 1, 0, 0, 15, 13, 0, 0)));
        tbl.push_back(v("reach_49_miss",  100, 149, PU,     ST,     0, 0, 1, 0, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("reach_48_hit",   100, 148, PU,     ST,     0, 0, 1, 0, mk(0, 1, 0, 0, 15, 13, 0, 0)));
        tbl.push_back(v("shield_block",   100, 130, PU,     SH,     0, 3, 1, 0, mk(0, 0, 0, 1, 15, 15, 0, 0)));
        tbl.push_back(v("shield_empty",   100, 130, PU,     SH,     0, 0, 1, 0, mk(0, 1, 0, 0, 15, 13, 0, 0)));
        tbl.push_back(v("jump_dodge",     100, 130, PU,     JU,     0, 0, 1, 0, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("crouch_dodge",   100, 130, PU,     CR,     0, 0, 1, 0, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("trade",          100, 120, PU,     L | PU, 0, 0, 1, 1, mk(1, 1, 0, 0, 13, 13, 0, 0)));
        tbl.push_back(v("wrong_facing",   100, 130, L | PU, ST,     0, 0, 1, 0, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("left_hit",       100, 130, WA,     L | PU, 0, 0, 0, 1, mk(1, 0, 0, 0, 13, 15, 0, 0)));
        tbl.push_back(v("left_reach_49",  100, 149, ST,     L | PU, 0, 0, 0, 1, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("equal_x_left",   200, 200, L | PU, ST,     0, 0, 1, 0, mk(0, 1, 0, 0, 15, 13, 0, 0)));
        tbl.push_back(v("equal_x_right",  200, 200, ST,     PU,     0, 0, 0, 1, mk(1, 0, 0, 0, 13, 15, 0, 0)));
        tbl.push_back(v("p1_right_miss",   50,  60, ST,     PU,     0, 0, 0, 1, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("no_wrap_right", 1000,   5, PU,     ST,     0, 0, 1, 0, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("no_wrap_left",     5,1000, L | PU, ST,     0, 0, 1, 0, mk(0, 0, 0, 0, 15, 15, 0, 0)));
        tbl.push_back(v("double_block",   100, 120, SH,     L | SH, 1, 1, 1, 1, mk(0, 0, 1, 1, 15, 15, 0, 0)));

        foreach (tbl[k]) begin
            set_players(tbl[k].x0, tbl[k].x1, tbl[k].a0, tbl[k].a1, tbl[k].s0, tbl[k].s1);
            cycle(1'b1, 1'b0, 1'b0, 1'b0, idle15, "restart");
            cycle(1'b0, 1'b0, tbl[k].r0, tbl[k].r1, tbl[k].exp, tbl[k].name);
            cycle(1'b0, 1'b0, 1'b0, 1'b0,
                  mk(0, 0, 0, 0, tbl[k].exp.health0, tbl[k].exp.health1, 0, 0), {tbl[k].name, "_pulse_end"});
        end

        // Invulnerability window after a clean hit, then normal evaluation again.
        set_players(10'd100, 10'd130, PU, ST, 4'd0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, idle15, "inv_restart");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 15, 13, 0, 0), "inv_first_hit");
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 15, 13, 0, 0), "inv_idle");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0, 15, 13, 0, 0), "inv_miss");
        for (int i = 0; i < 4; i++)
            cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 15, 13, 0, 0), "inv_idle2");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 15, 11, 0, 0), "inv_expired_hit");

        // new_round wins over a same-cycle attack and clears the window.
        cycle(1'b1, 1'b0, 1'b1, 1'b0, idle15, "restart_priority");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 15, 13, 0, 0), "hit_after_restart");

        // Reset in the middle of both windows.
        set_players(10'd100, 10'd120, PU, L | PU, 4'd0, 4'd0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, idle15, "rst_restart");
        cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 13, 13, 0, 0), "rst_trade");
        cycle(1'b0, 1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0, 13, 13, 0, 0), "rst_idle");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, idle15, "mid_window_reset");
        cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(1, 1, 0, 0, 13, 13, 0, 0), "hit_after_reset");

        // Knockout of player 1 with saturation, frozen OVER state, and restart.
        ko_run(1'b1, 1'b0, mk(0, 1, 0, 0, 1, 0, 1, 2'b01), "ko_p0_wins");
        cycle(1'b0, 1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0, 1, 0, 1, 2'b01), "over_ignores_attacks");
        cycle(1'b0, 1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0, 1, 0, 1, 2'b01), "over_holds");
        cycle(1'b1, 1'b0, 1'b0, 1'b0, idle15, "over_new_round");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, mk(0, 1, 0, 0, 15, 13, 0, 0), "fight_after_over");

        ko_run(1'b0, 1'b1, mk(1, 0, 0, 0, 0, 1, 1, 2'b10), "ko_p1_wins");
        ko_run(1'b1, 1'b1, mk(1, 1, 0, 0, 0, 0, 1, 2'b11), "ko_draw");
        cycle(1'b0, 1'b1, 1'b0, 1'b0, idle15, "reset_from_over");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/combat_resolver.md
# combat_resolver

Game-side responder to the two player blocks. Each cycle it takes both players' one-cycle `attack_request` pulses, action vectors, shield levels and x positions, and decides whether each punch hits, is blocked or misses. It owns both health registers, which feed back to the players' `health` inputs. It also runs a small round FSM that detects a knockout and reports the winner.

## Interface
Parameters:
- `XW`, 10: x-position width.
- `REACH`, 10'd48: maximum horizontal distance, in pixels, for a punch to connect.
- `DAMAGE`, 4'd2: health removed by a clean hit.
- `CHIP_DAMAGE`, 4'd0: health removed by a blocked hit.
- `INVULN_CYCLES`, 24'd12_500_000: post-hit invulnerability window (0.125 s at 100 MHz).

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `new_round` in 1: single-cycle pulse; restarts the round.
- `attack_req0`, `attack_req1` in 1: single-cycle attack pulses from player 0 and player 1.
- `action0`, `action1` in 7: player action vectors. Bit 6 is facing (0 = right, 1 = left). Bits 5:0 are one-hot: WALKING, CROUCHING, SHIELDING, JUMPING, PUNCHING, STANDING, from LSB.
- `shield0`, `shield1` in 4: current shield levels.
- `x0`, `x1` in XW: player x positions.
- `health0`, `health1` out 4: current health of each player.
- `hit0`, `hit1` out 1: one-cycle pulse; that player took a clean hit.
- `block0`, `block1` out 1: one-cycle pulse; that player blocked an attack.
- `game_over` out 1: high while the FSM is in OVER.
- `winner` out 2: 00 none, 01 player 0, 10 player 1, 11 draw.

## Operation
- **Reset.** Applies on any rising `clk` edge while `reset` = 1. Result: `health0` = `health1` = 15; all pulse outputs 0; `game_over` = 0; `winner` = 00; FSM in FIGHT; both invulnerability counters 0.
- **FSM states and transitions:**
  - FIGHT → OVER when either next-health value is 0.
  - OVER → FIGHT on `new_round`.
  - `new_round` in FIGHT also restarts the round.
  - A restart sets health to 15, clears the counters and sets `winner` = 00.
  - `new_round` takes priority over any attack in the same cycle.
- **Per-attacker evaluation** (attacker A, defender D), performed only in FIGHT and only when `attack_req`A = 1:
  - **Reach test.**
    - If A faces right: require x_D ≥ x_A and x_D − x_A ≤ REACH.
    - If A faces left: require x_A ≥ x_D and x_A − x_D ≤ REACH.
    - Compare before subtracting so the difference never wraps.
    - Equal positions satisfy both facings.
  - **Miss.** Reach test fails, D is JUMPING or CROUCHING, or D's invulnerability counter ≠ 0. Result: no effect.
  - **Block.** D is SHIELDING with shield_D ≥ 1. Result: `block`D pulses and health_D drops by CHIP_DAMAGE. The counter does not load.
  - **Hit.** All other cases. Result: `hit`D pulses, health_D drops by DAMAGE, and D's counter loads INVULN_CYCLES.
- **Health arithmetic.** Subtraction saturates at 0; health never wraps.
- **Simultaneous attacks.** Both attacks are evaluated independently in the same cycle (a trade). Both players can be damaged.
- **Winner encoding on entering OVER.**
  - Only health1 = 0 → 01.
  - Only health0 = 0 → 10.
  - Both reach 0 in the same cycle → 11.
- **Inputs ignored in OVER.** Attack requests are ignored. Health and `winner` hold until `new_round` or `reset`.
- **Invulnerability counters.** Each decrements by 1 per cycle while nonzero, in every FSM state.

## Timing
- **Latency.** Attack pulse sampled at edge N:
  - Health change, `hit`/`block` pulse and any FSM transition are all visible after edge N+1.
  - `game_over` rises in the same cycle that health first reads 0.
- **Pulse width.** All pulse outputs are exactly one cycle and registered.
- **Invulnerability window.**
  - After a hit registered at edge N+1, attacks on that defender are misses through edge N+INVULN_CYCLES.
  - An attack sampled once the counter has returned to 0 is evaluated normally.
- **Input sampling.** Action, shield and x inputs are sampled in the same cycle as `attack_req`. No extra input registering.
- **Mid-operation reset or `new_round`.** Either one, arriving mid-window, clears the counters immediately.

## Structure
- **Shared package.**
  - Action one-hot constants (WALKING … STANDING) and the facing-bit index (6); the player block uses the same constants.
  - Winner encodings.
  - FSM state encodings FIGHT and OVER.
- **Sub-module `hit_check`.**
  - Purely combinational.
  - Inputs: attacker x, facing and request; defender x, action, shield and invulnerable flag.
  - Outputs: `is_hit`, `is_block`.
  - Instantiated twice, once per direction.
- The health, counter and FSM registers stay in `combat_resolver`.

## Test plan
Default parameters throughout.
- **Clean hit, then invulnerability.** x0 = 100, x1 = 130, action0 facing right, action1 STANDING; pulse `attack_req0` → next cycle `hit1` = 1 and health1 = 13. A second pulse 5 cycles later leaves health1 = 13 and produces no pulse.
- **Out of reach.** x1 = 149 (distance 49) → no pulse, health unchanged. x1 = 148 (distance 48) → hit.
- **Block and dodge.** action1 SHIELDING with shield1 = 3 → `block1` = 1, health1 = 15. Shield1 = 0 → hit. action1 JUMPING → miss.
- **Trade.** Players face each other at distance 20; both request in the same cycle → `hit0` = `hit1` = 1 and health0 = health1 = 13 on the same cycle.
- **Knockout.** health1 = 1 when hit → health1 = 0 (saturated), `game_over` = 1, `winner` = 01. Further attacks change nothing. `new_round` → health 15/15, `winner` = 00, `game_over` = 0.
- **Reset mid-window.** Assert `reset` during a counter window → both health values 15 and the counters 0. A hit on the very next attack is accepted.
